// File: rtl/apb_regfile_slave.sv
// Purpose  : APB slave with DEPTH word-wide registers, byte strobes, range/alignment errors.
// Latency  : WAIT_CYCLES+1 cycles from the setup cycle to pready (WAIT_CYCLES=0 -> zero-wait APB).
// Backpress: pready held low for WAIT_CYCLES access cycles; dropping psel mid-access aborts silently.
//
// Ports:
//   pclk, preset            clock (rising edge) and synchronous active-low reset
//   psel, penable, pwrite   APB control
//   paddr [ADDR_W]          byte address; idx = paddr[ADDR_W-1:LSB], LSB = log2(DATA_W/8)
//   pwdata/pstrb            write data and byte-lane strobes
//   prdata/pready/pslverr   read data (0 unless a good read completes), handshake, error
//
// Build option: define APB_STRB_EN to honour pstrb per lane; otherwise every
// good write updates the full word and pstrb is ignored.
module apb_regfile_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int LANES = DATA_W / 8;
    localparam int LSB   = $clog2(LANES);
    localparam int IDX_W = ADDR_W - LSB;
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] regs [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [SEL_W-1:0]  sel;
    logic              range_err;
    logic              align_err;
    logic              err;
    logic [LANES-1:0]  lane_en;
    logic [DATA_W-1:0] bit_mask;
    logic              wr_en;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign idx = paddr[ADDR_W-1:LSB];
    // Low bits of idx pick the register; the upper bits only feed range_err,
    // so an out-of-range index can never alias onto a real register.
    assign sel = idx[SEL_W-1:0];
    assign range_err = ({1'b0, idx} >= (IDX_W+1)'(DEPTH));

    generate
        if (LSB == 0) begin : g_no_align
            // Byte-wide bus: every address is aligned.
            assign align_err = 1'b0;
        end else begin : g_align
            assign align_err = |paddr[LSB-1:0];
        end
    endgenerate

    assign err = range_err | align_err;

    // ------------------------------------------------------------------
    // Byte-lane enables
    // ------------------------------------------------------------------
`ifdef APB_STRB_EN
    assign lane_en = pstrb;
`else
    logic unused_strb;
    assign unused_strb = ^pstrb;
    assign lane_en     = '1;
`endif

    always_comb begin
        bit_mask = '0;
        for (int b = 0; b < LANES; b++) begin
            bit_mask[8*b +: 8] = {8{lane_en[b]}};
        end
    end

    // ------------------------------------------------------------------
    // FSM: state and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // Only a proper setup cycle starts a transfer; penable
                // without a preceding setup is ignored.
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (penable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------
    assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0) && psel && penable;
    assign pslverr = pready & err;
    assign prdata  = (pready && !pwrite && !err) ? regs[sel] : '0;
    assign wr_en   = pready && pwrite && !err;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel == SEL_W'(i)) begin
                    regs[i] <= (regs[i] & ~bit_mask) | (pwdata & bit_mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Purpose  : self-checking bench for apb_regfile_slave (three wait-state configurations).
// Latency  : checks WAIT_CYCLES+1 access cycles per transfer for WAIT_CYCLES = 1, 3, 0.
// Backpress: waits on pready with a bounded cycle budget per transfer.
module tb_apb_regfile_slave;

    logic        pclk;
    logic        preset;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata_v [3];
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;

    int n_checks = 0;
    int n_fail   = 0;
    int stray    = 0;
    int cyc      = 0;

`ifdef APB_STRB_EN
    localparam logic [31:0] EXP_PART = 32'hDE22BE44;
    localparam logic [31:0] EXP_ZERO = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_PART = 32'h11223344;
    localparam logic [31:0] EXP_ZERO = 32'h5555_5555;
`endif

    // Index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=3, index 2: WAIT_CYCLES=0.
    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(1)) u_dut (
        .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(3)) u_dut_w3 (
        .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(0)) u_dut_w0 (
        .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // pslverr and prdata must be quiet whenever pready is low.
    always @(negedge pclk) begin
        for (int k = 0; k < 3; k++) begin
            if (!pready_v[k] && (pslverr_v[k] || prdata_v[k] != 32'h0)) stray <= stray + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Starts and ends at 1 time unit after a rising edge so transfers can be chained back-to-back.
    task automatic apb_xfer(input int tgt, input logic wr, input logic [7:0] addr,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] rd, output logic er, output int lat);
        logic done;
        psel_v       = 3'b000;
        psel_v[tgt]  = 1'b1;
        penable      = 1'b0;
        pwrite       = wr;
        paddr        = addr;
        pwdata       = wd;
        pstrb        = st;
        rd           = 32'h0;
        er           = 1'b0;
        done         = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        lat     = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            if (pready_v[tgt]) begin
                rd   = prdata_v[tgt];
                er   = pslverr_v[tgt];
                done = 1'b1;
            end else begin
                @(posedge pclk); #1;
                lat++;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout: pready got 0 after 40 cycles, required 1 (addr 0x%02h)", addr);
        end
        @(posedge pclk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          c0;

    initial begin
        vecs[0]  = '{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 8'h08, 32'h11223344, 4'h5, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 8'h08, 32'h0,        4'h0, EXP_PART,     1'b0};
        vecs[4]  = '{1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 8'h40, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 8'h06, 32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 8'h06, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 8'h3C, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 8'h3C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[12] = '{1'b1, 8'h14, 32'h55555555, 4'h0, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 8'h14, 32'h0,        4'h0, EXP_ZERO,     1'b0};
        vecs[14] = '{1'b0, 8'h41, 32'h0,        4'h0, 32'h0,        1'b1};

        preset  = 1'b0;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        repeat (3) @(posedge pclk);
        #1;
        @(negedge pclk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_pready_%0d", k), {31'h0, pready_v[k]}, 32'h0);
            check($sformatf("reset_pslverr_%0d", k), {31'h0, pslverr_v[k]}, 32'h0);
            check($sformatf("reset_prdata_%0d", k), prdata_v[k], 32'h0);
        end
        @(posedge pclk); #1;
        preset = 1'b1;

        // Every register reads zero after reset, two cycles from setup.
        for (int i = 0; i < 16; i++) begin
            apb_xfer(0, 1'b0, 8'(i * 4), 32'h0, 4'h0, rd, er, lat);
            check($sformatf("init_rd_%0d", i), rd, 32'h0);
            check($sformatf("init_err_%0d", i), {31'h0, er}, 32'h0);
            check($sformatf("init_lat_%0d", i), lat, 2);
        end

        // penable without setup: must be ignored.
        psel_v  = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 8'h18;
        pwdata  = 32'h87654321;
        pstrb   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check($sformatf("no_setup_pready_%0d", i), {31'h0, pready_v[0]}, 32'h0);
            @(posedge pclk); #1;
        end
        psel_v  = 3'b000;
        penable = 1'b0;
        apb_xfer(0, 1'b0, 8'h18, 32'h0, 4'h0, rd, er, lat);
        check("no_setup_rd", rd, 32'h0);

        // Table-driven main function, errors and strobes.
        for (int i = 0; i < 15; i++) begin
            apb_xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].st, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), lat, 2);
        end

        // Wait-state configurations.
        apb_xfer(1, 1'b1, 8'h04, 32'h0BADF00D, 4'hF, rd, er, lat);
        check("w3_wr_lat", lat, 4);
        check("w3_wr_err", {31'h0, er}, 32'h0);
        apb_xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, rd, er, lat);
        check("w3_rd_lat", lat, 4);
        check("w3_rd_data", rd, 32'h0BADF00D);
        apb_xfer(2, 1'b1, 8'h04, 32'h600DCAFE, 4'hF, rd, er, lat);
        check("w0_wr_lat", lat, 1);
        apb_xfer(2, 1'b0, 8'h04, 32'h0, 4'h0, rd, er, lat);
        check("w0_rd_lat", lat, 1);
        check("w0_rd_data", rd, 32'h600DCAFE);

        // Abort: psel dropped in the wait state, then master resumes without setup.
        psel_v  = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h0C;
        pwdata  = 32'h77777777;
        pstrb   = 4'hF;
        @(posedge pclk); #1;
        psel_v  = 3'b000;
        penable = 1'b1;
        @(negedge pclk);
        check("abort_pready_drop", {31'h0, pready_v[0]}, 32'h0);
        @(posedge pclk); #1;
        psel_v = 3'b001;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            check($sformatf("abort_resume_pready_%0d", i), {31'h0, pready_v[0]}, 32'h0);
            @(posedge pclk); #1;
        end
        psel_v  = 3'b000;
        penable = 1'b0;
        apb_xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, rd, er, lat);
        check("abort_rd_0c", rd, 32'h0);

        // Reset asserted on what would be the completing edge.
        psel_v  = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h0C;
        pwdata  = 32'h99999999;
        pstrb   = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(negedge pclk);
        check("rst_mid_pready", {31'h0, pready_v[0]}, 32'h0);
        @(posedge pclk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        apb_xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, rd, er, lat);
        check("rst_mid_rd_0c", rd, 32'h0);
        apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, lat);
        check("rst_mid_rd_08", rd, 32'h0);

        // Back-to-back write then read, no idle cycle between.
        c0 = cyc;
        apb_xfer(0, 1'b1, 8'h10, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        apb_xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, er, lat);
        check("b2b_rd_data", rd, 32'hA5A5A5A5);
        check("b2b_rd_lat", lat, 2);
        check("b2b_total_cycles", cyc - c0, 6);

        @(posedge pclk); #1;
        check("stray_outputs", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
